datapath_result_checker: RTL and testbench
==========================================

// Module: datapath_result_checker
// PURPOSE
//   Self-checking monitor at the far end of the datapath test harness. Observes register-file
//   write strobes and writeback data, compares each write against an expected (reg, value) table,
//   and reports pass/fail, error count and first-failure details to board LEDs or a testbench.
// PARAMETERS
//   NUM_CHECKS  19  number of expected register writes in the table (1..31)
//   TIMEOUT     64  max idle cycles between consecutive writes before declaring failure
//   CNT_W       8   width of err_count; saturates at all-ones
// PORTS
//   clk         in   1   system clock, all logic on posedge
//   rst         in   1   synchronous, active-high reset
//   reg_en      in   16  register-file write enables (expected one-hot or zero)
//   wb_data     in   16  writeback bus value written when reg_en != 0
//   busy        out  1   checker armed and waiting for or consuming writes
//   done        out  1   sequence complete (all checks seen, error stop, or timeout); sticky
//   pass        out  1   done with zero errors and no timeout; sticky
//   err_count   out  CNT_W  number of mismatching/illegal writes
//   fail_step   out  5   table index of first failure (NUM_CHECKS on timeout)
//   fail_reg    out  4   register index observed at first failure
//   fail_data   out  16  wb_data observed at first failure
// BEHAVIOUR
//   - Reset: state=RUN, step=0, idle_cnt=0, busy=1, done=0, pass=0, err_count=0, fail_step=0,
//     fail_reg=0, fail_data=0, first_fail=0. Reset in any state restarts the check from step 0.
//   - States: RUN -> DONE. RUN samples each cycle; DONE holds all outputs until rst.
//   - Cycle with reg_en==0: no check; idle_cnt++; idle_cnt==TIMEOUT-1 -> DONE, pass=0,
//     fail_step=NUM_CHECKS if no earlier failure recorded.
//   - Cycle with reg_en!=0: idle_cnt<=0; reg index = position of set bit; check against
//     EXP_TABLE[step]. Mismatch if reg_en not one-hot, index != exp_reg, or wb_data != exp_val.
//   - Mismatch: err_count++ (saturating); if first failure, latch step/reg/wb_data into fail_*.
//     Non-one-hot: fail_reg = lowest set bit index.
//   - step++ on every write; write with step==NUM_CHECKS-1 -> DONE next cycle, pass=(err_count
//     after this write ==0). Latency: done/pass valid 1 cycle after final write.
//   - Writes arriving in DONE are ignored; step never wraps.
//   - busy = (state==RUN). Outputs are registered; no combinational input->output path.
// CONFIGURATION
//   CHECKER_STOP_ON_ERR_EN defined: first mismatch moves straight to DONE (pass=0); err_count==1.
//   Undefined: checker continues through all NUM_CHECKS writes, counting every mismatch;
//   fail_* still hold the first failure only.
// STRUCTURE
//   - Package datapath_check_pkg: exp_entry_t {reg[3:0], val[15:0]}, EXP_TABLE constant array
//     sized by NUM_CHECKS, checker state encoding, and the onehot_to_index function.
//   - One sub-module natural: onehot_encoder16 (16-bit enable -> 4-bit index + onehot_ok flag).
//   - Main module: step/idle counters, compare logic, 2-state FSM, fail capture registers.
// TESTING
//   1. Drive full golden sequence (r1<=0x7fff, r2<=0xffff, r3<=0x8000, ... all 19) one write per
//      2 cycles -> done=1, pass=1, err_count=0 one cycle after 19th write; busy=0.
//   2. Step 1 writes r2<=0xfffe -> fail_step=1, fail_reg=2, fail_data=0xfffe, pass=0 at end,
//      err_count=1 (macro off) / done=1 next cycle (macro on).
//   3. Step 0 with reg_en=16'h0006, wb_data=0x7fff -> illegal one-hot, fail_reg=1, err_count=1.
//   4. Stop writes after step 5 -> done=1 after exactly TIMEOUT=64 idle cycles, pass=0,
//      fail_step=19.
//   5. Assert rst for 1 cycle mid-run at step 10 -> all outputs return to reset values;
//      replaying golden sequence then yields pass=1.
//   6. Macro off, corrupt steps 3, 7, 12 -> err_count=3, fail_step=3; extra write in DONE
//      leaves all outputs unchanged.

Source files
------------

// File: rtl/datapath_result_checker_pkg.sv
// Shared types, expected-write table and helpers for the datapath result checker.
package datapath_check_pkg;

  localparam int unsigned NUM_CHECKS  = 19;
  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned STEP_W      = 5;
  localparam int unsigned REG_W       = 4;
  localparam int unsigned DATA_W      = 16;

  typedef struct packed {
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] val;
  } exp_entry_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } chk_state_e;

  // Golden register-write sequence, one entry per expected write in order.
  localparam exp_entry_t EXP_TABLE [NUM_CHECKS] = '{
    '{4'd1,  16'h7fff}, '{4'd2,  16'hffff}, '{4'd3,  16'h8000}, '{4'd4,  16'h0001},
    '{4'd5,  16'h1234}, '{4'd6,  16'h5678}, '{4'd7,  16'h9abc}, '{4'd8,  16'hdef0},
    '{4'd9,  16'h0000}, '{4'd10, 16'haaaa}, '{4'd11, 16'h5555}, '{4'd12, 16'h00ff},
    '{4'd13, 16'hff00}, '{4'd14, 16'h0f0f}, '{4'd15, 16'hf0f0}, '{4'd0,  16'hc3c3},
    '{4'd1,  16'h8001}, '{4'd2,  16'h7ffe}, '{4'd3,  16'hfffe}
  };

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [REG_W-1:0] onehot_to_index(input logic [DATA_W-1:0] v);
    logic [REG_W-1:0] idx;
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) idx = REG_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/datapath_result_checker_if.sv
// Monitor bus: observed register-file writes in, checker status out.
interface datapath_result_checker_if #(parameter int unsigned CNT_W = 8);
  logic [15:0]      reg_en;
  logic [15:0]      wb_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [4:0]       fail_step;
  logic [3:0]       fail_reg;
  logic [15:0]      fail_data;

  modport master (output reg_en, wb_data,
                  input  busy, done, pass, err_count, fail_step, fail_reg, fail_data);
  modport slave  (input  reg_en, wb_data,
                  output busy, done, pass, err_count, fail_step, fail_reg, fail_data);
endinterface

// File: rtl/datapath_result_checker_onehot_encoder16.sv
// 16-bit write-enable to register index, with a flag for exactly-one-bit-set.
module onehot_encoder16
  import datapath_check_pkg::*;
(
  input  logic [15:0] en,
  output logic [3:0]  idx_c,
  output logic        onehot_ok_c
);

  assign idx_c       = onehot_to_index(en);
  assign onehot_ok_c = (en != '0) && ((en & (en - 16'd1)) == '0);

endmodule

// File: rtl/datapath_result_checker.sv
// Compares observed register writes against EXP_TABLE and reports pass/fail status.
// Optional CHECKER_STOP_ON_ERR_EN: end the check at the first mismatching write.
module datapath_result_checker
  import datapath_check_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  datapath_result_checker_if.slave  bus
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  chk_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              first_fail_q, first_fail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [STEP_W-1:0] fail_step_q, fail_step_d;
  logic [REG_W-1:0]  fail_reg_q, fail_reg_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  logic [REG_W-1:0]  idx_c;
  logic              onehot_ok_c;
  exp_entry_t        exp_c;
  logic              mismatch_c;

  onehot_encoder16 u_enc (
    .en          (bus.reg_en),
    .idx_c       (idx_c),
    .onehot_ok_c (onehot_ok_c)
  );

  // step can sit one past the table once the last write has been taken
  assign exp_c      = (step_q < STEP_W'(NUM_CHECKS)) ? EXP_TABLE[step_q] : '0;
  assign mismatch_c = !onehot_ok_c || (idx_c != exp_c.reg_idx) || (bus.wb_data != exp_c.val);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    idle_d       = idle_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    fail_step_d  = fail_step_q;
    fail_reg_d   = fail_reg_q;
    fail_data_d  = fail_data_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.reg_en == '0) begin
          idle_d = idle_q + IDLE_W'(1);
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = ST_DONE;
            pass_d  = 1'b0;
            if (!first_fail_q) begin
              first_fail_d = 1'b1;
              fail_step_d  = STEP_W'(NUM_CHECKS);
            end
          end
        end else begin
          idle_d = '0;
          step_d = step_q + STEP_W'(1);
          if (mismatch_c) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (!first_fail_q) begin
              first_fail_d = 1'b1;
              fail_step_d  = step_q;
              fail_reg_d   = idx_c;
              fail_data_d  = bus.wb_data;
            end
`ifdef CHECKER_STOP_ON_ERR_EN
            state_d = ST_DONE;
`endif
          end
          if (step_q == STEP_W'(NUM_CHECKS - 1)) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_RUN;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      step_q       <= '0;
      idle_q       <= '0;
      err_q        <= '0;
      first_fail_q <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_step_q  <= '0;
      fail_reg_q   <= '0;
      fail_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_step_q  <= fail_step_d;
      fail_reg_q   <= fail_reg_d;
      fail_data_q  <= fail_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_step = fail_step_q;
  assign bus.fail_reg  = fail_reg_q;
  assign bus.fail_data = fail_data_q;

endmodule

// File: tb/tb_datapath_result_checker.sv
// Directed bench for datapath_result_checker; honours CHECKER_STOP_ON_ERR_EN when defined.
module tb_datapath_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [3:0]  gold_reg [19];
  logic [15:0] gold_val [19];

  datapath_result_checker_if #(.CNT_W(8)) bus ();

  datapath_result_checker #(.TIMEOUT(64), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_write(input logic [15:0] en, input logic [15:0] data);
    bus.reg_en  = en;
    bus.wb_data = data;
    tick();
    bus.reg_en  = '0;
    bus.wb_data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Golden writes for steps [from, to), one write then one idle cycle each; corrupted steps get data^1.
  task automatic play(input int from, input int to, input logic [18:0] corrupt);
    for (int i = from; i < to; i++) begin
      do_write(16'h0001 << gold_reg[i], corrupt[i] ? (gold_val[i] ^ 16'h0001) : gold_val[i]);
      idle(1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic p,
                            input logic [7:0] e, input logic [4:0] fs, input logic [3:0] fr,
                            input logic [15:0] fd);
    chk({tag, ".busy"},      32'(bus.busy),      32'(b));
    chk({tag, ".done"},      32'(bus.done),      32'(d));
    chk({tag, ".pass"},      32'(bus.pass),      32'(p));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(e));
    chk({tag, ".fail_step"}, 32'(bus.fail_step), 32'(fs));
    chk({tag, ".fail_reg"},  32'(bus.fail_reg),  32'(fr));
    chk({tag, ".fail_data"}, 32'(bus.fail_data), 32'(fd));
  endtask

  initial begin
    gold_reg = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
    gold_val = '{16'h7fff, 16'hffff, 16'h8000, 16'h0001, 16'h1234, 16'h5678, 16'h9abc,
                 16'hdef0, 16'h0000, 16'haaaa, 16'h5555, 16'h00ff, 16'hff00, 16'h0f0f,
                 16'hf0f0, 16'hc3c3, 16'h8001, 16'h7ffe, 16'hfffe};
    bus.reg_en  = '0;
    bus.wb_data = '0;

    // reset state
    apply_reset();
    chk_status("reset", 1'b1, 1'b0, 1'b0, 8'd0, 5'd0, 4'd0, 16'h0000);

    // full golden sequence; completion appears right after the 19th write
    play(0, 18, '0);
    chk("golden.pre_done", 32'(bus.done), 32'd0);
    chk("golden.pre_busy", 32'(bus.busy), 32'd1);
    do_write(16'h0001 << gold_reg[18], gold_val[18]);
    chk_status("golden", 1'b0, 1'b1, 1'b1, 8'd0, 5'd0, 4'd0, 16'h0000);

    // wrong data at step 1
    apply_reset();
    play(0, 1, '0);
    do_write(16'h0004, 16'hfffe);
`ifdef CHECKER_STOP_ON_ERR_EN
    chk("baddata.done_next", 32'(bus.done), 32'd1);
`else
    chk("baddata.done_next", 32'(bus.done), 32'd0);
`endif
    idle(1);
    play(2, 19, '0);
    chk_status("baddata", 1'b0, 1'b1, 1'b0, 8'd1, 5'd1, 4'd2, 16'hfffe);

    // non-one-hot enable at step 0: lowest set bit reported
    apply_reset();
    do_write(16'h0006, 16'h7fff);
`ifdef CHECKER_STOP_ON_ERR_EN
    chk_status("onehot.now", 1'b0, 1'b1, 1'b0, 8'd1, 5'd0, 4'd1, 16'h7fff);
`else
    chk_status("onehot.now", 1'b1, 1'b0, 1'b0, 8'd1, 5'd0, 4'd1, 16'h7fff);
`endif
    idle(1);
    play(1, 19, '0);
    chk_status("onehot.end", 1'b0, 1'b1, 1'b0, 8'd1, 5'd0, 4'd1, 16'h7fff);

    // timeout: writes stop after step 5; play already spent one idle cycle
    apply_reset();
    play(0, 6, '0);
    idle(62);
    chk("timeout.63_idle_done", 32'(bus.done), 32'd0);
    idle(1);
    chk_status("timeout", 1'b0, 1'b1, 1'b0, 8'd0, 5'd19, 4'd0, 16'h0000);

    // reset mid-run at step 10, then replay
    apply_reset();
    play(0, 9, '0);
    do_write(16'h0001 << gold_reg[9], 16'h0bad);
    idle(1);
`ifndef CHECKER_STOP_ON_ERR_EN
    chk("midreset.pre_err", 32'(bus.err_count), 32'd1);
`endif
    apply_reset();
    chk_status("midreset", 1'b1, 1'b0, 1'b0, 8'd0, 5'd0, 4'd0, 16'h0000);
    play(0, 19, '0);
    chk_status("replay", 1'b0, 1'b1, 1'b1, 8'd0, 5'd0, 4'd0, 16'h0000);

    // corrupt steps 3, 7 and 12; then a write while done must change nothing
    apply_reset();
    play(0, 19, 19'(1 << 3) | 19'(1 << 7) | 19'(1 << 12));
`ifdef CHECKER_STOP_ON_ERR_EN
    chk_status("multi", 1'b0, 1'b1, 1'b0, 8'd1, 5'd3, 4'd4, 16'h0000);
    do_write(16'h0020, 16'h1234);
    chk_status("multi.ignored", 1'b0, 1'b1, 1'b0, 8'd1, 5'd3, 4'd4, 16'h0000);
`else
    chk_status("multi", 1'b0, 1'b1, 1'b0, 8'd3, 5'd3, 4'd4, 16'h0000);
    do_write(16'h0020, 16'h1234);
    chk_status("multi.ignored", 1'b0, 1'b1, 1'b0, 8'd3, 5'd3, 4'd4, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
